// File: rtl/fp_mult_pkg.sv
// Shared definitions for the single-precision multiplier result path:
// status bit positions and the packed result payload carried through the FIFO.
package fp_mult_pkg;

    localparam int unsigned ST_ZERO    = 0;
    localparam int unsigned ST_INF     = 1;
    localparam int unsigned ST_NAN     = 2;
    localparam int unsigned ST_TINY    = 3;
    localparam int unsigned ST_HUGE    = 4;
    localparam int unsigned ST_INEXACT = 5;

    localparam int unsigned Z_W      = 32;
    localparam int unsigned STATUS_W = 8;
    localparam int unsigned FLAG_W   = 6;

    typedef logic [STATUS_W-1:0] fp_status_t;

    typedef struct packed {
        logic [Z_W-1:0] z;
        fp_status_t     st;
    } fp_res_t;

    // Results that count as exceptional events: NaN, underflow or overflow.
    function automatic logic is_exc_event(input fp_status_t st);
        return st[ST_NAN] | st[ST_TINY] | st[ST_HUGE];
    endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// Show-ahead result FIFO: power-of-two depth, wrapping pointers, registered
// occupancy count plus registered not_full / not_empty flags.
module fp_res_fifo
    import fp_mult_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  fp_res_t                wdata,
    output fp_res_t                rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   not_full,
    output logic                   not_empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fp_res_fifo: DEPTH must be a power of two and at least 2");
    end

    fp_res_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;

    // Caller only pushes when not full and only pops when not empty.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            not_full  <= 1'b0;
            not_empty <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count_q   <= count_d;
            not_full  <= (count_d != CW'(DEPTH));
            not_empty <= (count_d != CW'(0));
        end
    end

    // Payload storage needs no reset; readers qualify it with not_empty.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign count = count_q;

endmodule

// File: rtl/fp_mult_result_stage.sv
// Result stage after the fp multiplier: FIFO buffering, sticky exception flags
// and an optional exception event counter (enabled by FP_RES_EXC_CNT_EN).
module fp_mult_result_stage
    import fp_mult_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_z,
    input  logic [7:0]             in_status,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_z,
    output logic [7:0]             out_status,
    output logic [5:0]             sticky_flags,
    input  logic                   sticky_clr,
    output logic [$clog2(DEPTH):0] fill_level,
    output logic [CNT_W-1:0]       exc_cnt
);

    logic    push;
    logic    pop;
    fp_res_t wr_res;
    fp_res_t head;

    assign push   = in_valid & in_ready;
    assign pop    = out_valid & out_ready;
    assign wr_res = '{z: in_z, st: in_status};

    fp_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wdata     (wr_res),
        .rdata     (head),
        .count     (fill_level),
        .not_full  (in_ready),
        .not_empty (out_valid)
    );

    // Storage contents are not reset, so the head is masked when empty.
    assign out_z      = out_valid ? head.z  : 32'd0;
    assign out_status = out_valid ? head.st : 8'd0;

    // Clear wins over accumulate, but a flag arriving in the clear cycle is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_flags <= '0;
        end else if (sticky_clr) begin
            sticky_flags <= push ? in_status[FLAG_W-1:0] : FLAG_W'(0);
        end else if (push) begin
            sticky_flags <= sticky_flags | in_status[FLAG_W-1:0];
        end
    end

`ifdef FP_RES_EXC_CNT_EN
    logic exc_hit;

    assign exc_hit = push & is_exc_event(in_status);

    // Saturating event counter; never wraps back to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exc_cnt <= '0;
        end else if (sticky_clr) begin
            exc_cnt <= '0;
        end else if (exc_hit && (exc_cnt != {CNT_W{1'b1}})) begin
            exc_cnt <= exc_cnt + CNT_W'(1);
        end
    end
`else
    assign exc_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_fp_mult_result_stage.sv
// Directed self-checking bench for fp_mult_result_stage (DEPTH=4, CNT_W=2).
// Expected exc_cnt follows FP_RES_EXC_CNT_EN when the bench is compiled.
module tb_fp_mult_result_stage;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 2;
`ifdef FP_RES_EXC_CNT_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_z;
    logic [7:0]       in_status;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_z;
    logic [7:0]       out_status;
    logic [5:0]       sticky_flags;
    logic             sticky_clr;
    logic [2:0]       fill_level;
    logic [CNT_W-1:0] exc_cnt;

    int n_pass;
    int n_total;

    fp_mult_result_stage #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_z         (in_z),
        .in_status    (in_status),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_z        (out_z),
        .out_status   (out_status),
        .sticky_flags (sticky_flags),
        .sticky_clr   (sticky_clr),
        .fill_level   (fill_level),
        .exc_cnt      (exc_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_z       = 32'd0;
        in_status  = 8'd0;
        out_ready  = 1'b0;
        sticky_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        step();
        step();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || fill_level !== 3'd0 || out_z !== 32'd0
            || out_status !== 8'd0 || sticky_flags !== 6'd0 || exc_cnt !== 2'd0)
            $display("FAIL reset_state: ov=%b ir=%b fill=%0d z=%h st=%h sticky=%h exc=%0d, want all 0",
                     out_valid, in_ready, fill_level, out_z, out_status, sticky_flags, exc_cnt);
        else n_pass++;
        rst = 1'b1;
        step();
        n_total++;
        if (in_ready !== 1'b1 || fill_level !== 3'd0) $display("FAIL reset_release: ir=%b fill=%0d, want 1 0", in_ready, fill_level);
        else n_pass++;

        // Fill three entries carrying every flag, then reset mid-stream.
        in_valid  = 1'b1;
        in_status = 8'h3F;
        for (int i = 0; i < 3; i++) begin
            in_z = 32'h1000_0000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        n_total++;
        if (fill_level !== 3'd3 || sticky_flags !== 6'h3F) $display("FAIL reset_prefill: fill=%0d sticky=%h, want 3 3f", fill_level, sticky_flags);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (fill_level !== 3'd0 || out_valid !== 1'b0 || sticky_flags !== 6'd0 || in_ready !== 1'b0 || exc_cnt !== 2'd0)
            $display("FAIL reset_midstream: fill=%0d ov=%b sticky=%h ir=%b exc=%0d, want 0 0 0 0 0",
                     fill_level, out_valid, sticky_flags, in_ready, exc_cnt);
        else n_pass++;
        in_valid = 1'b1;
        step();
        step();
        n_total++;
        if (in_ready !== 1'b0 || fill_level !== 3'd0) $display("FAIL reset_held: ir=%b fill=%0d, want 0 0", in_ready, fill_level);
        else n_pass++;
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        n_total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || fill_level !== 3'd0) $display("FAIL reset_after: ir=%b ov=%b fill=%0d, want 1 0 0", in_ready, out_valid, fill_level);
        else n_pass++;
    endtask

    task automatic test_order();
        logic [31:0] words [3];
        words[0] = 32'h3F80_0000;
        words[1] = 32'h4000_0000;
        words[2] = 32'h4040_0000;
        idle_inputs();
        in_valid  = 1'b1;
        in_z      = words[0];
        in_status = 8'h80;
        n_total++;
        if (out_valid !== 1'b0 || out_z !== 32'd0) $display("FAIL order_pre: ov=%b z=%h, want 0 0", out_valid, out_z);
        else n_pass++;
        step();
        n_total++;
        if (out_valid !== 1'b1 || out_z !== words[0] || out_status !== 8'h80)
            $display("FAIL order_latency: ov=%b z=%h st=%h, want 1 %h 80", out_valid, out_z, out_status, words[0]);
        else n_pass++;
        for (int i = 1; i < 3; i++) begin
            in_z      = words[i];
            in_status = 8'h40;
            step();
        end
        in_valid = 1'b0;
        n_total++;
        if (fill_level !== 3'd3) $display("FAIL order_fill: fill=%0d, want 3", fill_level);
        else n_pass++;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (out_valid !== 1'b1 || out_z !== words[i]) $display("FAIL order_pop%0d: ov=%b z=%h, want 1 %h", i, out_valid, out_z, words[i]);
            else n_pass++;
            step();
        end
        n_total++;
        if (out_valid !== 1'b0 || out_z !== 32'd0 || out_status !== 8'd0 || fill_level !== 3'd0)
            $display("FAIL order_empty: ov=%b z=%h st=%h fill=%0d, want 0 0 0 0", out_valid, out_z, out_status, fill_level);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        idle_inputs();
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_z = 32'hA000_0000 + 32'(i);
            step();
        end
        n_total++;
        if (in_ready !== 1'b0 || fill_level !== 3'd4) $display("FAIL full_state: ir=%b fill=%0d, want 0 4", in_ready, fill_level);
        else n_pass++;
        // Offer a word while full and popping: it must not be taken.
        in_z      = 32'hDEAD_BEEF;
        out_ready = 1'b1;
        step();
        n_total++;
        if (fill_level !== 3'd3 || in_ready !== 1'b1 || out_z !== 32'hA000_0001)
            $display("FAIL full_pop_no_push: fill=%0d ir=%b z=%h, want 3 1 a0000001", fill_level, in_ready, out_z);
        else n_pass++;
        in_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            n_total++;
            if (out_z !== 32'hA000_0000 + 32'(i)) $display("FAIL full_drain%0d: z=%h, want %h", i, out_z, 32'hA000_0000 + 32'(i));
            else n_pass++;
            step();
        end
        n_total++;
        if (out_valid !== 1'b0 || fill_level !== 3'd0) $display("FAIL full_drained: ov=%b fill=%0d, want 0 0", out_valid, fill_level);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_concurrent();
        idle_inputs();
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_z = 32'hC000_0000 + 32'(i);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_z = 32'hC000_0000 + 32'(i + 2);
            n_total++;
            if (out_z !== 32'hC000_0000 + 32'(i)) $display("FAIL conc_head%0d: z=%h, want %h", i, out_z, 32'hC000_0000 + 32'(i));
            else n_pass++;
            step();
            n_total++;
            if (fill_level !== 3'd2) $display("FAIL conc_fill%0d: fill=%0d, want 2", i, fill_level);
            else n_pass++;
        end
        in_valid = 1'b0;
        for (int i = 10; i < 12; i++) begin
            n_total++;
            if (out_z !== 32'hC000_0000 + 32'(i)) $display("FAIL conc_tail%0d: z=%h, want %h", i, out_z, 32'hC000_0000 + 32'(i));
            else n_pass++;
            step();
        end
        n_total++;
        if (fill_level !== 3'd0) $display("FAIL conc_drained: fill=%0d, want 0", fill_level);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    task automatic test_sticky();
        idle_inputs();
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        n_total++;
        if (sticky_flags !== 6'd0) $display("FAIL sticky_clear: sticky=%h, want 00", sticky_flags);
        else n_pass++;
        in_valid  = 1'b1;
        in_status = 8'h20;
        step();
        in_status = 8'h04;
        step();
        in_valid = 1'b0;
        n_total++;
        if (sticky_flags !== 6'h24) $display("FAIL sticky_accum: sticky=%h, want 24", sticky_flags);
        else n_pass++;
        in_valid   = 1'b1;
        in_status  = 8'h10;
        sticky_clr = 1'b1;
        step();
        idle_inputs();
        n_total++;
        if (sticky_flags !== 6'h10) $display("FAIL sticky_clr_push: sticky=%h, want 10", sticky_flags);
        else n_pass++;
        // Idle cycle must leave the flags alone.
        step();
        n_total++;
        if (sticky_flags !== 6'h10) $display("FAIL sticky_hold: sticky=%h, want 10", sticky_flags);
        else n_pass++;
        out_ready = 1'b1;
        repeat (3) step();
        out_ready = 1'b0;
    endtask

    task automatic test_exc_cnt();
        logic [CNT_W-1:0] want;
        idle_inputs();
        sticky_clr = 1'b1;
        step();
        sticky_clr = 1'b0;
        n_total++;
        if (exc_cnt !== 2'd0 || fill_level !== 3'd0) $display("FAIL exc_clear: exc=%0d fill=%0d, want 0 0", exc_cnt, fill_level);
        else n_pass++;
        // Unused status bits travel with the word; NaN counts as an event.
        in_valid  = 1'b1;
        in_z      = 32'h7FC0_0000;
        in_status = 8'hC4;
        step();
        want = EXC_EN ? 2'd1 : 2'd0;
        n_total++;
        if (out_status !== 8'hC4 || out_z !== 32'h7FC0_0000 || exc_cnt !== want)
            $display("FAIL exc_first: st=%h z=%h exc=%0d, want c4 7fc00000 %0d", out_status, out_z, exc_cnt, want);
        else n_pass++;
        // Inexact alone is not an exception event.
        out_ready = 1'b1;
        in_status = 8'h20;
        step();
        n_total++;
        if (exc_cnt !== want) $display("FAIL exc_inexact: exc=%0d, want %0d", exc_cnt, want);
        else n_pass++;
        in_status = 8'h04;
        step();
        want = EXC_EN ? 2'd2 : 2'd0;
        n_total++;
        if (exc_cnt !== want) $display("FAIL exc_two: exc=%0d, want %0d", exc_cnt, want);
        else n_pass++;
        repeat (3) step();
        in_valid = 1'b0;
        want = EXC_EN ? 2'd3 : 2'd0;
        n_total++;
        if (exc_cnt !== want) $display("FAIL exc_saturate: exc=%0d, want %0d", exc_cnt, want);
        else n_pass++;
        repeat (3) step();
        n_total++;
        if (fill_level !== 3'd0 || exc_cnt !== want) $display("FAIL exc_final: fill=%0d exc=%0d, want 0 %0d", fill_level, exc_cnt, want);
        else n_pass++;
        out_ready = 1'b0;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        idle_inputs();
        test_reset();
        test_order();
        test_full();
        test_concurrent();
        test_sticky();
        test_exc_cnt();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
